// File: rtl/move_input_ctrl_if.sv
// ============================================================================
// Module      : move_input_ctrl_if
// Description : Mouse-side inputs and board-manager-side outputs of the
//               move input controller, grouped as one bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface move_input_ctrl_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        game_over;
    logic [3:0]  board_code;
    logic [63:0] possible_moves;
    logic [5:0]  query_xy;
    logic [5:0]  figure_position;
    logic        pick_place;
    logic        turn;
    logic        hover_valid;
    logic [5:0]  hover_xy;
    logic        move_done;

    modport master (
        input  xpos,
        input  ypos,
        input  mouse_left,
        input  game_over,
        input  board_code,
        input  possible_moves,
        output query_xy,
        output figure_position,
        output pick_place,
        output turn,
        output hover_valid,
        output hover_xy,
        output move_done
    );

    modport slave (
        output xpos,
        output ypos,
        output mouse_left,
        output game_over,
        output board_code,
        output possible_moves,
        input  query_xy,
        input  figure_position,
        input  pick_place,
        input  turn,
        input  hover_valid,
        input  hover_xy,
        input  move_done
    );
endinterface

`default_nettype wire

// File: rtl/move_input_ctrl.sv
// ============================================================================
// Module      : move_input_ctrl
// Description : Turns mouse clicks over the rendered board into pick/place
//               requests for the board manager, enforcing turn order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module move_input_ctrl #(
    parameter logic [11:0] BOARD_X0 = 12'd192,
    parameter logic [11:0] BOARD_Y0 = 12'd64,
    parameter logic [2:0]  SQ_LOG2  = 3'd6
) (
    input  logic              clk,
    input  logic              rst,
    move_input_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SRC  = 3'd1,
        ST_CHECK_SRC = 3'd2,
        ST_HOLD      = 3'd3,
        ST_PLACE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        mouse_left_q;
    logic        hover_valid_q, hover_valid_d;
    logic [5:0]  hover_xy_q, hover_xy_d;
    logic [5:0]  query_xy_q, query_xy_d;
    logic [5:0]  src_q, src_d;
    logic [5:0]  tgt_q, tgt_d;
    logic [5:0]  fig_pos_q, fig_pos_d;
    logic        pick_place_q, pick_place_d;
    logic        turn_q, turn_d;
    logic        move_done_q, move_done_d;

    logic [11:0] dx, dy;
    logic [11:0] dx_sq, dy_sq;
    logic        in_area;
    logic        click;
    logic        target_ok;

    // Pixel offsets wrap when left of / above the board, so the explicit
    // lower-bound compares are what reject those positions.
    assign dx      = bus.xpos - BOARD_X0;
    assign dy      = bus.ypos - BOARD_Y0;
    assign dx_sq   = dx >> SQ_LOG2;
    assign dy_sq   = dy >> SQ_LOG2;
    assign in_area = (bus.xpos >= BOARD_X0) && (bus.ypos >= BOARD_Y0) &&
                     (dx_sq < 12'd8) && (dy_sq < 12'd8);

    assign click = bus.mouse_left & ~mouse_left_q;

    function automatic logic is_own(input logic [3:0] code, input logic side);
        if (side)
            return (code >= 4'd7) && (code <= 4'd12);
        return (code >= 4'd1) && (code <= 4'd6);
    endfunction

    always_comb begin
        hover_valid_d = in_area;
        hover_xy_d    = hover_xy_q;
        if (in_area)
            hover_xy_d = {dy_sq[2:0], dx_sq[2:0]};
    end

    // Cancelling onto the source square is always accepted as a target.
    assign target_ok = (hover_xy_q == src_q) || bus.possible_moves[hover_xy_q];

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        query_xy_d   = query_xy_q;
        src_d        = src_q;
        tgt_d        = tgt_q;
        fig_pos_d    = fig_pos_q;
        pick_place_d = pick_place_q;
        turn_d       = turn_q;
        move_done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (click && hover_valid_q && !bus.game_over) begin
                    query_xy_d = hover_xy_q;
                    src_d      = hover_xy_q;
                    state_d    = ST_WAIT_SRC;
                end
            end
            ST_WAIT_SRC: begin
                state_d = ST_CHECK_SRC;
            end
            ST_CHECK_SRC: begin
                if (is_own(bus.board_code, turn_q)) begin
                    fig_pos_d    = src_q;
                    pick_place_d = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (click && hover_valid_q && target_ok) begin
                    tgt_d   = hover_xy_q;
                    state_d = ST_PLACE;
                end
            end
            ST_PLACE: begin
                fig_pos_d    = tgt_q;
                pick_place_d = 1'b0;
                if (tgt_q != src_q) begin
                    turn_d      = ~turn_q;
                    move_done_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mouse_left_q  <= 1'b0;
            hover_valid_q <= 1'b0;
            hover_xy_q    <= 6'd0;
            query_xy_q    <= 6'd0;
            src_q         <= 6'd0;
            tgt_q         <= 6'd0;
            fig_pos_q     <= 6'd0;
            pick_place_q  <= 1'b0;
            turn_q        <= 1'b0;
            move_done_q   <= 1'b0;
        end else begin
            mouse_left_q  <= bus.mouse_left;
            hover_valid_q <= hover_valid_d;
            hover_xy_q    <= hover_xy_d;
            query_xy_q    <= query_xy_d;
            src_q         <= src_d;
            tgt_q         <= tgt_d;
            fig_pos_q     <= fig_pos_d;
            pick_place_q  <= pick_place_d;
            turn_q        <= turn_d;
            move_done_q   <= move_done_d;
        end
    end

    assign bus.query_xy        = query_xy_q;
    assign bus.figure_position = fig_pos_q;
    assign bus.pick_place      = pick_place_q;
    assign bus.turn            = turn_q;
    assign bus.hover_valid     = hover_valid_q;
    assign bus.hover_xy        = hover_xy_q;
    assign bus.move_done       = move_done_q;

endmodule

`default_nettype wire

// File: tb/tb_move_input_ctrl.sv
// ============================================================================
// Module      : tb_move_input_ctrl
// Description : Click-level bench for move_input_ctrl against a game model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_move_input_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_input_ctrl_if bus();

    move_input_ctrl #(
        .BOARD_X0 (12'd192),
        .BOARD_Y0 (12'd64),
        .SQ_LOG2  (3'd6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] board [64];
    always @(posedge clk) bus.board_code <= board[bus.query_xy];

    int n_checks = 0;
    int n_fail   = 0;
    int md_cycles = 0;
    always @(negedge clk) if (bus.move_done === 1'b1) md_cycles++;

    // Game-level model: what the player should see after each click
    int m_turn, m_held, m_src, m_fig, m_query, m_hv, m_hxy, m_moves;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit own_piece(input int code, input int side);
        if (side == 1) return (code >= 7) && (code <= 12);
        return (code >= 1) && (code <= 6);
    endfunction

    task automatic model_reset();
        m_turn = 0; m_held = 0; m_src = 0; m_fig = 0;
        m_query = 0; m_hv = 0; m_hxy = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_query"}, bus.query_xy, 0);
        check_eq({tag, "_fig"},   bus.figure_position, 0);
        check_eq({tag, "_pick"},  bus.pick_place, 0);
        check_eq({tag, "_turn"},  bus.turn, 0);
        check_eq({tag, "_hv"},    bus.hover_valid, 0);
        check_eq({tag, "_hxy"},   bus.hover_xy, 0);
        check_eq({tag, "_md"},    bus.move_done, 0);
    endtask

    task automatic hover_to(input int x, input int y);
        bus.xpos = 12'(x);
        bus.ypos = 12'(y);
        @(negedge clk);
        m_hv = (x >= 192 && x < 192 + 512 && y >= 64 && y < 64 + 512) ? 1 : 0;
        if (m_hv == 1) m_hxy = ((y - 64) / 64) * 8 + (x - 192) / 64;
        check_eq("hover_valid", bus.hover_valid, 64'(m_hv));
        check_eq("hover_xy", bus.hover_xy, 64'(m_hxy));
    endtask

    function automatic int px_x(input int sq);
        return 192 + (sq % 8) * 64 + int'($urandom_range(0, 63));
    endfunction

    function automatic int px_y(input int sq);
        return 64 + (sq / 8) * 64 + int'($urandom_range(0, 63));
    endfunction

    task automatic do_click(input int x, input int y, input int hold_cycles);
        int prev_held;
        hover_to(x, y);
        prev_held = m_held;
        if (m_held == 0) begin
            if (m_hv == 1 && bus.game_over == 1'b0) begin
                m_query = m_hxy;
                if (own_piece(int'(board[m_hxy]), m_turn)) begin
                    m_held = 1; m_src = m_hxy; m_fig = m_hxy;
                end
            end
        end else if (m_hv == 1 && (m_hxy == m_src || bus.possible_moves[m_hxy] == 1'b1)) begin
            m_held = 0;
            m_fig  = m_hxy;
            if (m_hxy != m_src) begin
                m_turn = 1 - m_turn;
                m_moves++;
            end
        end
        bus.mouse_left = 1'b1;
        @(negedge clk);
        check_eq("query_xy_t0", bus.query_xy, 64'(m_query));
        check_eq("pick_t0", bus.pick_place, 64'(prev_held));
        repeat (2) @(negedge clk);
        check_eq("pick_t2", bus.pick_place, 64'(m_held));
        repeat (hold_cycles) @(negedge clk);
        bus.mouse_left = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pick_place", bus.pick_place, 64'(m_held));
        check_eq("figure_position", bus.figure_position, 64'(m_fig));
        check_eq("turn", bus.turn, 64'(m_turn));
        check_eq("query_xy", bus.query_xy, 64'(m_query));
        check_eq("move_done_cycles", 64'(md_cycles), 64'(m_moves));
        check_eq("move_done_idle", bus.move_done, 0);
    endtask

    task automatic click_sq(input int sq);
        do_click(px_x(sq), px_y(sq), 0);
    endtask

    initial begin
        int x, y;
        rst = 1'b1;
        bus.xpos = 12'd0;
        bus.ypos = 12'd0;
        bus.mouse_left = 1'b0;
        bus.game_over = 1'b0;
        bus.possible_moves = 64'd0;
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
        model_reset();
        m_moves = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Pick from square 52, move to 44
        board[52] = 4'd1;
        bus.possible_moves = 64'd1 << 44;
        do_click(192 + 4*64 + 5, 64 + 6*64 + 5, 0);
        check_eq("pick52_fig", bus.figure_position, 52);
        check_eq("pick52_query", bus.query_xy, 52);
        click_sq(44);
        check_eq("move44_turn", bus.turn, 1);
        check_eq("move44_fig", bus.figure_position, 44);
        check_eq("move44_md", 64'(md_cycles), 1);

        // Black replies so white is to move again
        board[8] = 4'd7;
        bus.possible_moves = 64'd1 << 16;
        click_sq(8);
        click_sq(16);

        // Wrong colour, empty, move marker
        board[12] = 4'd7;
        click_sq(12);
        check_eq("wrong_colour_pick", bus.pick_place, 0);
        board[36] = 4'd0;
        click_sq(36);
        board[36] = 4'hD;
        click_sq(36);
        check_eq("marker_pick", bus.pick_place, 0);

        // Illegal target, then cancel on the source
        board[50] = 4'd2;
        bus.possible_moves = 64'd0;
        click_sq(50);
        click_sq(20);
        check_eq("illegal_pick", bus.pick_place, 1);
        click_sq(50);
        check_eq("cancel_fig", bus.figure_position, 50);
        check_eq("cancel_turn", bus.turn, 0);

        // Boundaries and outside clicks
        hover_to(191, 100);
        hover_to(192 + 511, 100);
        check_eq("col7", bus.hover_xy, 7);
        hover_to(192 + 512, 100);
        do_click(100, 100, 0);
        board[0] = 4'd3;
        click_sq(0);
        do_click(900, 300, 0);
        check_eq("outside_hold", bus.pick_place, 1);
        click_sq(0);

        // Held button acts once
        board[1] = 4'd4;
        do_click(px_x(1), px_y(1), 100);
        check_eq("held_single", bus.pick_place, 1);
        click_sq(1);

        // game_over blocks picks
        bus.game_over = 1'b1;
        board[2] = 4'd5;
        click_sq(2);
        bus.game_over = 1'b0;

        // Randomised play
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 64; i++) board[i] = 4'($urandom_range(0, 15));
            bus.possible_moves = {$urandom, $urandom};
            bus.game_over = ($urandom_range(0, 9) == 0);
            if (m_held == 1 && $urandom_range(0, 3) == 0) begin
                x = px_x(m_src); y = px_y(m_src);
            end else if ($urandom_range(0, 4) != 0) begin
                x = 192 + int'($urandom_range(0, 511));
                y = 64 + int'($urandom_range(0, 511));
            end else begin
                x = int'($urandom_range(0, 1023));
                y = int'($urandom_range(0, 767));
            end
            do_click(x, y, int'($urandom_range(0, 3)));
        end
        bus.game_over = 1'b0;

        // Reset while holding a piece
        if (m_held == 0) begin
            board[3] = (m_turn == 1) ? 4'd9 : 4'd3;
            click_sq(3);
        end
        check_eq("pre_reset_hold", bus.pick_place, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("reset_hold");
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
